// File: rtl/reg_group_param_pkg.sv
// rtl/reg_group_param_pkg.sv - shared defaults, register index names and address helpers
package reg_group_param_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int NREGS_DEF  = 4;

    // Architectural register indices for the 4-register configuration.
    localparam int X0 = 0;
    localparam int X1 = 1;
    localparam int X2 = 2;
    localparam int X3 = 3;

    function automatic logic in_range(input int unsigned addr, input int unsigned nregs);
        return addr < nregs;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits with issue-over-writeback priority
module reg_scoreboard
    import reg_group_param_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int RAWIDTH = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr_valid,
    input  logic [RAWIDTH-1:0] clr_addr,
    input  logic               set_valid,
    input  logic [RAWIDTH-1:0] set_addr,
    input  logic [RAWIDTH-1:0] rd1_addr,
    input  logic [RAWIDTH-1:0] rd2_addr,
    output logic               rd1_busy,
    output logic               rd2_busy,
    output logic               busy_any
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    // Set is applied after clear so a fresh issue supersedes a same-cycle writeback.
    always_comb begin
        busy_next = busy;
        if (clr_valid && in_range(32'(clr_addr), NREGS))
            busy_next[clr_addr] = 1'b0;
        if (set_valid && in_range(32'(set_addr), NREGS))
            busy_next[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else if (en)
            busy <= busy_next;
    end

    assign rd1_busy = in_range(32'(rd1_addr), NREGS) ? busy[rd1_addr] : 1'b0;
    assign rd2_busy = in_range(32'(rd2_addr), NREGS) ? busy[rd2_addr] : 1'b0;
    assign busy_any = |busy;

endmodule

// File: rtl/reg_group_param.sv
// rtl/reg_group_param.sv - parametrised register group with bypass, scoreboard and debug port
module reg_group_param
    import reg_group_param_pkg::*;
#(
    parameter int               DWIDTH    = DWIDTH_DEF,
    parameter int               NREGS     = NREGS_DEF,
    localparam int              RAWIDTH   = $clog2(NREGS),
    parameter logic [DWIDTH-1:0] RESET_VAL = '0,
    parameter int               BYPASS    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [RAWIDTH-1:0] rs1_addr,
    output logic [DWIDTH-1:0]  rs1_data,
    output logic               rs1_busy,
    input  logic [RAWIDTH-1:0] rs2_addr,
    output logic [DWIDTH-1:0]  rs2_data,
    output logic               rs2_busy,
    input  logic               we,
    input  logic [RAWIDTH-1:0] wd_addr,
    input  logic [DWIDTH-1:0]  wd_data,
    input  logic               issue_valid,
    input  logic [RAWIDTH-1:0] issue_addr,
    input  logic               dbg_we,
    input  logic [RAWIDTH-1:0] dbg_addr,
    input  logic [DWIDTH-1:0]  dbg_wdata,
    output logic [DWIDTH-1:0]  dbg_rdata,
    output logic               busy_any
);

    logic [DWIDTH-1:0] regs [NREGS];
    logic              wr_ok;
    logic              dbg_ok;
    logic              byp1;
    logic              byp2;
    logic              sb_busy1;
    logic              sb_busy2;

    assign wr_ok  = en && we && in_range(32'(wd_addr), NREGS);
    assign dbg_ok = dbg_we && in_range(32'(dbg_addr), NREGS);

    // Debug write is last so it wins a same-address collision with the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= RESET_VAL;
        end else begin
            if (wr_ok)
                regs[wd_addr] <= wd_data;
            if (dbg_ok)
                regs[dbg_addr] <= dbg_wdata;
        end
    end

    assign byp1 = (BYPASS != 0) && wr_ok && (wd_addr == rs1_addr);
    assign byp2 = (BYPASS != 0) && wr_ok && (wd_addr == rs2_addr);

    assign rs1_data = byp1 ? wd_data :
                      in_range(32'(rs1_addr), NREGS) ? regs[rs1_addr] : '0;
    assign rs2_data = byp2 ? wd_data :
                      in_range(32'(rs2_addr), NREGS) ? regs[rs2_addr] : '0;
    assign rs1_busy = byp1 ? 1'b0 : sb_busy1;
    assign rs2_busy = byp2 ? 1'b0 : sb_busy2;

    assign dbg_rdata = in_range(32'(dbg_addr), NREGS) ? regs[dbg_addr] : '0;

    reg_scoreboard #(
        .NREGS(NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr_valid(we),
        .clr_addr (wd_addr),
        .set_valid(issue_valid),
        .set_addr (issue_addr),
        .rd1_addr (rs1_addr),
        .rd2_addr (rs2_addr),
        .rd1_busy (sb_busy1),
        .rd2_busy (sb_busy2),
        .busy_any (busy_any)
    );

endmodule

// File: tb/tb_reg_group_param.sv
// tb/tb_reg_group_param.sv - directed table and sequence checks for reg_group_param
module tb_reg_group_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus for the two 4x16 instances (bypass on / off)
    logic        en, we, iv, dwe;
    logic [1:0]  r1, r2, wa, ia, da;
    logic [15:0] wd, dwd;
    logic [15:0] a_r1d, a_r2d, a_dbg, b_r1d, b_r2d, b_dbg;
    logic        a_b1, a_b2, a_any, b_b1, b_b2, b_any;

    // Stimulus for the 5x32 instance
    logic        e_en, e_we, e_iv, e_dwe;
    logic [2:0]  e_r1, e_r2, e_wa, e_ia, e_da;
    logic [31:0] e_wd, e_dwd, e_r1d, e_r2d, e_dbg;
    logic        e_b1, e_b2, e_any;

    int n_checks = 0;
    int n_fail   = 0;

    reg_group_param #(.DWIDTH(16), .NREGS(4), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .rs1_addr(r1), .rs1_data(a_r1d), .rs1_busy(a_b1),
        .rs2_addr(r2), .rs2_data(a_r2d), .rs2_busy(a_b2),
        .we(we), .wd_addr(wa), .wd_data(wd),
        .issue_valid(iv), .issue_addr(ia),
        .dbg_we(dwe), .dbg_addr(da), .dbg_wdata(dwd), .dbg_rdata(a_dbg),
        .busy_any(a_any)
    );

    reg_group_param #(.DWIDTH(16), .NREGS(4), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .rs1_addr(r1), .rs1_data(b_r1d), .rs1_busy(b_b1),
        .rs2_addr(r2), .rs2_data(b_r2d), .rs2_busy(b_b2),
        .we(we), .wd_addr(wa), .wd_data(wd),
        .issue_valid(iv), .issue_addr(ia),
        .dbg_we(dwe), .dbg_addr(da), .dbg_wdata(dwd), .dbg_rdata(b_dbg),
        .busy_any(b_any)
    );

    reg_group_param #(.DWIDTH(32), .NREGS(5), .BYPASS(1)) dut_e (
        .clk(clk), .rst(rst), .en(e_en),
        .rs1_addr(e_r1), .rs1_data(e_r1d), .rs1_busy(e_b1),
        .rs2_addr(e_r2), .rs2_data(e_r2d), .rs2_busy(e_b2),
        .we(e_we), .wd_addr(e_wa), .wd_data(e_wd),
        .issue_valid(e_iv), .issue_addr(e_ia),
        .dbg_we(e_dwe), .dbg_addr(e_da), .dbg_wdata(e_dwd), .dbg_rdata(e_dbg),
        .busy_any(e_any)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        en = 1'b1; we = 1'b0; iv = 1'b0; dwe = 1'b0;
        wa = 2'd0; wd = 16'h0; ia = 2'd0; da = 2'd0; dwd = 16'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        en, we;
        logic [1:0]  wa;
        logic [15:0] wd;
        logic        iv;
        logic [1:0]  ia;
        logic        dwe;
        logic [1:0]  da;
        logic [15:0] dwd;
        logic [1:0]  r1, r2;
        logic [15:0] e_r1;
        logic        e_b1;
        logic [15:0] e_r2;
        logic        e_b2;
        logic        e_any;
        logic [15:0] e_dbg;
    } vec_t;

    vec_t vt [11];
    logic [15:0] sum;

    initial begin
        // Starts with x0=7 x1=5 x2=0x1234 x3=0, nothing busy
        vt[0]  = '{1'b1,1'b1,2'd3,16'h1111,1'b0,2'd0,1'b1,2'd3,16'hBEEF,2'd3,2'd2, 16'h1111,1'b0,16'h1234,1'b0,1'b0,16'h0000};
        vt[1]  = '{1'b1,1'b1,2'd2,16'h2222,1'b0,2'd0,1'b1,2'd3,16'h3333,2'd3,2'd0, 16'hBEEF,1'b0,16'h0007,1'b0,1'b0,16'hBEEF};
        vt[2]  = '{1'b1,1'b0,2'd0,16'h0000,1'b0,2'd0,1'b0,2'd3,16'h0000,2'd2,2'd3, 16'h2222,1'b0,16'h3333,1'b0,1'b0,16'h3333};
        vt[3]  = '{1'b1,1'b0,2'd0,16'h0000,1'b1,2'd1,1'b0,2'd1,16'h0000,2'd1,2'd0, 16'h0005,1'b0,16'h0007,1'b0,1'b0,16'h0005};
        vt[4]  = '{1'b1,1'b1,2'd1,16'h0055,1'b1,2'd1,1'b0,2'd1,16'h0000,2'd1,2'd0, 16'h0055,1'b0,16'h0007,1'b0,1'b1,16'h0005};
        vt[5]  = '{1'b1,1'b0,2'd0,16'h0000,1'b0,2'd0,1'b0,2'd1,16'h0000,2'd1,2'd1, 16'h0055,1'b1,16'h0055,1'b1,1'b1,16'h0055};
        vt[6]  = '{1'b1,1'b0,2'd0,16'h0000,1'b1,2'd1,1'b0,2'd1,16'h0000,2'd1,2'd0, 16'h0055,1'b1,16'h0007,1'b0,1'b1,16'h0055};
        vt[7]  = '{1'b1,1'b1,2'd1,16'h0066,1'b0,2'd0,1'b0,2'd1,16'h0000,2'd1,2'd1, 16'h0066,1'b0,16'h0066,1'b0,1'b1,16'h0055};
        vt[8]  = '{1'b1,1'b0,2'd0,16'h0000,1'b0,2'd0,1'b0,2'd1,16'h0000,2'd1,2'd0, 16'h0066,1'b0,16'h0007,1'b0,1'b0,16'h0066};
        vt[9]  = '{1'b0,1'b1,2'd0,16'hFFFF,1'b1,2'd2,1'b0,2'd0,16'h0000,2'd2,2'd0, 16'h2222,1'b0,16'h0007,1'b0,1'b0,16'h0007};
        vt[10] = '{1'b1,1'b0,2'd0,16'h0000,1'b0,2'd0,1'b0,2'd0,16'h0000,2'd2,2'd0, 16'h2222,1'b0,16'h0007,1'b0,1'b0,16'h0007};

        idle();
        r1 = 2'd0; r2 = 2'd0;
        e_en = 1'b0; e_we = 1'b0; e_iv = 1'b0; e_dwe = 1'b0;
        e_r1 = 3'd0; e_r2 = 3'd0; e_wa = 3'd0; e_ia = 3'd0; e_da = 3'd0;
        e_wd = 32'h0; e_dwd = 32'h0;

        // Reset state, no clock edge needed
        #3;
        check("reset_rs1_data", 32'(a_r1d), 32'h0);
        check("reset_busy_any", 32'(a_any), 32'h0);
        check("reset_dbg_rdata", 32'(a_dbg), 32'h0);
        check("reset_wide_rs1", e_r1d, 32'h0);
        next_cycle();
        rst = 1'b0;

        // Preload with en=0, then add through the datapath
        en = 1'b0; dwe = 1'b1; da = 2'd0; dwd = 16'd2;
        next_cycle();
        da = 2'd1; dwd = 16'd3;
        next_cycle();
        idle();
        r1 = 2'd0; r2 = 2'd1;
        @(negedge clk);
        sum = a_r1d + a_r2d;
        we = 1'b1; wa = 2'd1; wd = sum;
        next_cycle();
        r1 = 2'd1; r2 = 2'd0; we = 1'b0;
        @(negedge clk);
        sum = a_r1d + a_r2d;
        we = 1'b1; wa = 2'd0; wd = sum;
        next_cycle();
        idle();
        da = 2'd0; #1;
        check("add_x0", 32'(a_dbg), 32'd7);
        da = 2'd1; #1;
        check("add_x1", 32'(a_dbg), 32'd5);

        // Bypass versus stored-value read
        next_cycle();
        dwe = 1'b1; da = 2'd2; dwd = 16'h00AA;
        next_cycle();
        idle();
        we = 1'b1; wa = 2'd2; wd = 16'h1234; r1 = 2'd2;
        @(negedge clk);
        check("bypass_on_rs1", 32'(a_r1d), 32'h1234);
        check("bypass_off_rs1", 32'(b_r1d), 32'h00AA);
        next_cycle();
        we = 1'b0;
        @(negedge clk);
        check("bypass_off_next", 32'(b_r1d), 32'h1234);
        next_cycle();

        for (int i = 0; i < 11; i++) begin
            en = vt[i].en; we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
            iv = vt[i].iv; ia = vt[i].ia; dwe = vt[i].dwe; da = vt[i].da;
            dwd = vt[i].dwd; r1 = vt[i].r1; r2 = vt[i].r2;
            @(negedge clk);
            check($sformatf("vec%0d_rs1_data", i), 32'(a_r1d), 32'(vt[i].e_r1));
            check($sformatf("vec%0d_rs1_busy", i), 32'(a_b1), 32'(vt[i].e_b1));
            check($sformatf("vec%0d_rs2_data", i), 32'(a_r2d), 32'(vt[i].e_r2));
            check($sformatf("vec%0d_rs2_busy", i), 32'(a_b2), 32'(vt[i].e_b2));
            check($sformatf("vec%0d_busy_any", i), 32'(a_any), 32'(vt[i].e_any));
            check($sformatf("vec%0d_dbg_rdata", i), 32'(a_dbg), 32'(vt[i].e_dbg));
            next_cycle();
        end

        // Async reset between edges with x0=7 and x1 busy
        idle();
        iv = 1'b1; ia = 2'd1;
        next_cycle();
        idle();
        r1 = 2'd1;
        check("pre_reset_busy_any", 32'(a_any), 32'h1);
        check("pre_reset_x0", 32'(a_dbg), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_x0", 32'(a_dbg), 32'h0);
        check("async_reset_busy_any", 32'(a_any), 32'h0);
        check("async_reset_rs1_busy", 32'(a_b1), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        // 5x32 instance: out-of-range addresses and the top register
        e_en = 1'b1; e_we = 1'b1; e_wa = 3'd6; e_wd = 32'h12345678;
        e_iv = 1'b1; e_ia = 3'd7; e_dwe = 1'b1; e_da = 3'd5; e_dwd = 32'hAAAA5555;
        e_r1 = 3'd7; e_r2 = 3'd6;
        @(negedge clk);
        check("wide_oor_rs1_data", e_r1d, 32'h0);
        check("wide_oor_rs2_nobypass", e_r2d, 32'h0);
        check("wide_oor_rs2_busy", 32'(e_b2), 32'h0);
        next_cycle();
        e_we = 1'b0; e_iv = 1'b0; e_dwe = 1'b0; e_r2 = 3'd5;
        #1;
        check("wide_oor_read7", e_r1d, 32'h0);
        check("wide_oor_busy7", 32'(e_b1), 32'h0);
        check("wide_oor_busy_any", 32'(e_any), 32'h0);
        check("wide_oor_read5", e_r2d, 32'h0);
        next_cycle();
        e_we = 1'b1; e_wa = 3'd4; e_wd = 32'hDEADBEEF; e_r1 = 3'd4;
        @(negedge clk);
        check("wide_x4_bypass", e_r1d, 32'hDEADBEEF);
        next_cycle();
        e_we = 1'b0; e_da = 3'd4; e_r2 = 3'd6;
        #1;
        check("wide_x4_read", e_r1d, 32'hDEADBEEF);
        check("wide_x4_dbg", e_dbg, 32'hDEADBEEF);
        check("wide_read6_after", e_r2d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_group_param.md
Name: reg_group_param

Overview:
Parametrised successor to the CPU's fixed 4x16-bit register group. Provides NREGS x DWIDTH registers with two combinational read ports, one datapath write port with optional write-to-read bypass, a per-register busy scoreboard for multi-cycle ops, and a debug port. The debug port lets benches preload and inspect registers without hierarchical pokes. It sits in data_path between decode and ALU writeback.

Parameters:
DWIDTH, 16, register data width
NREGS, 4, number of architectural registers (2..64, need not be power of two)
RAWIDTH, $clog2(NREGS), register address width (derived, not overridden)
RESET_VAL, 0, value loaded into every register on reset
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  datapath enable; gates datapath write and scoreboard updates
rs1_addr  in  RAWIDTH  read port 1 address
rs1_data  out  DWIDTH  read port 1 data
rs1_busy  out  1  register rs1_addr has a pending write
rs2_addr  in  RAWIDTH  read port 2 address
rs2_data  out  DWIDTH  read port 2 data
rs2_busy  out  1  register rs2_addr has a pending write
we  in  1  datapath write enable
wd_addr  in  RAWIDTH  datapath write address
wd_data  in  DWIDTH  datapath write data
issue_valid  in  1  multi-cycle op issued; marks issue_addr busy
issue_addr  in  RAWIDTH  destination of issued op
dbg_we  in  1  debug write enable (ignores en)
dbg_addr  in  RAWIDTH  debug read/write address
dbg_wdata  in  DWIDTH  debug write data
dbg_rdata  out  DWIDTH  stored value at dbg_addr (never bypassed)
busy_any  out  1  OR of all busy bits

Behaviour:
- Reset (async, rst=1): all registers = RESET_VAL, all busy bits = 0. The design resets immediately with no clock edge. Pending writes in the same cycle are lost.
- Reads are combinational, 0-cycle latency. addr >= NREGS: data = 0, busy = 0.
- Bypass is active when BYPASS=1, en=1, we=1, wd_addr==rsN_addr and wd_addr<NREGS. Under bypass, rsN_data = wd_data and rsN_busy = 0. Debug writes are never bypassed.
- Datapath write: at posedge, if en && we && wd_addr<NREGS, then reg[wd_addr] <= wd_data. en=0 means no write.
- Debug write: at posedge, if dbg_we && dbg_addr<NREGS, then reg[dbg_addr] <= dbg_wdata, regardless of en.
- Same cycle, same address for debug and datapath writes: the debug write wins. Different addresses: both writes commit.
- Scoreboard update at posedge when en=1:
  - A datapath write clears busy[wd_addr].
  - issue_valid sets busy[issue_addr].
  - Set and clear on the same address in the same cycle: set wins, because a new issue supersedes the old writeback.
  - Out-of-range addresses are ignored.
  - en=0 freezes the scoreboard.
  - Debug writes do not touch busy.
- Issue to an already-busy register: stays busy with no error; the first write clears it.
- busy_any is combinational from the busy register.
- No X on any output after reset for in-range or out-of-range addresses.

Decomposition:
- Shared package/header (rtl/regfile.vh, alongside opcode.vh): default DWIDTH, default NREGS, and register index macros X0..X3 for the 4-reg configuration. Benches and data_path use these instead of local `define copies.
- One sub-module: reg_scoreboard (NREGS busy bits, set/clear priority logic, busy_any). Storage array and bypass muxes stay in reg_group_param.

Test Plan:
1. Preload and add: dbg write x0=2, x1=3 with en=0, then en=1. Execute datapath writes x1<=x0+x1, then x0<=x1+x0 (values computed in bench). Required: dbg_rdata at x0 = 7, at x1 = 5.
2. Bypass: x2=0x00AA stored; in one cycle we=1, wd_addr=2, wd_data=0x1234, rs1_addr=2. Required: rs1_data=0x1234 in that cycle. With BYPASS=0 the same stimulus gives 0x00AA that cycle and 0x1234 the next.
3. Write collision: dbg_we and we both to x3 (dbg_wdata=0xBEEF, wd_data=0x1111). Required: x3=0xBEEF. With dbg to x3 and datapath to x2 instead, both values land.
4. Scoreboard: issue x1 gives rs1_busy=1 and busy_any=1. Same-cycle issue x1 plus write x1 leaves busy=1. A later write to x1 gives busy=0 and busy_any=0. With en=0, issue has no effect.
5. Async reset mid-operation: raise rst between edges with x0=7 and busy[1]=1. Required: x0=RESET_VAL and busy_any=0 before the next clk edge.
6. NREGS=5, DWIDTH=32: write to addr 6 is ignored, read of addr 7 returns 0 and busy 0, and addr 4 writes and reads 0xDEADBEEF.
